iob_eth_tx_arb: RTL and testbench
=================================

# iob_eth_tx_arb

Transmit-side controller that shares the Ethernet core's single TX buffer and send mechanism between two frame requesters (A and B). It arbitrates between them and drives the core's native CPU register interface as a bus master. For the granted requester it polls TX-ready, streams the frame words into the TX buffer, programs the byte count, and pulses the send bit. It sits between two producers (e.g. CPU and a packet engine) and the Ethernet core's slave port.

## Interface

Parameters:
- `ADDR_W`, 12: master address width, equal to the Ethernet core register-map width.
- `STATUS_ADDR`, 0: status register address; bit 0 is tx_ready.
- `NBYTES_ADDR`, 0: TX_NBYTES register address.
- `SEND_ADDR`, 0: SEND register address.
- `DATA_WR_ADDR`, 0: base address of the TX buffer window, one address per 32-bit word.
- `POLL_TIMEOUT`, 16'd1000: maximum status reads before the frame aborts.

Ports:
- `clk` in 1: system clock; the block has a single clock domain.
- `rstn` in 1: reset, synchronous and active-low.
- `a_req` / `b_req` in 1: frame request; held high until `*_ack`.
- `a_nbytes` / `b_nbytes` in 11: frame length in bytes; stable while `*_req` is high.
- `a_dvalid` / `b_dvalid` in 1: frame data word valid.
- `a_wdata` / `b_wdata` in 32: frame data word, byte 0 in bits [7:0].
- `a_dready` / `b_dready` out 1: data word accepted.
- `a_ack` / `b_ack` out 1: one-cycle done pulse.
- `a_err` / `b_err` out 1: qualifies `*_ack`; high when the frame was aborted.
- `m_valid` out 1: master request.
- `m_addr` out ADDR_W: master address.
- `m_wdata` out 32: master write data.
- `m_wstrb` out 4: write strobe; 0 means read.
- `m_rdata` in 32: read data, valid when `m_ready` is high.
- `m_ready` in 1: transfer completes in any cycle where `m_valid && m_ready`.

## Operation

FSM states: IDLE, POLL, DATA, NBYTES, SEND1, SEND0, DONE.

- **IDLE**
  - No requester: stay in IDLE.
  - Granted frame with nbytes = 0: go to DONE with err = 1; no bus activity occurs.
  - Otherwise: latch the grant and nbytes, load `words = (nbytes+3)>>2`, clear the poll count, and go to POLL.
- **POLL**: read STATUS_ADDR with wstrb 0.
  - On completion with rdata[0] = 1: go to DATA.
  - Otherwise increment the poll count.
  - When the count reaches POLL_TIMEOUT: go to DONE with err = 1.
- **DATA**:
  - `m_valid` = granted `dvalid`.
  - `m_addr` = DATA_WR_ADDR + word index; the index is 9 bits, starting at 0.
  - `m_wdata` = granted `wdata`, `m_wstrb` = 4'hF.
  - Granted `dready` = `m_ready` (combinational); the other requester's `dready` = 0.
  - After the word at index `words-1` completes: go to NBYTES.
- **NBYTES**: write {21'b0, nbytes} to NBYTES_ADDR, then go to SEND1.
- **SEND1**: write 1 to SEND_ADDR, then go to SEND0.
- **SEND0**: write 0 to SEND_ADDR, then go to DONE with err = 0.
- **DONE**: pulse the granted `*_ack` for one cycle with `*_err`, then go to IDLE. A requester is not re-arbitrated until the cycle after its ack.
- **Writes**: in NBYTES, SEND1 and SEND0, `m_valid` is held high until `m_ready`. `m_addr` and `m_wdata` stay constant while `m_valid` is high and `m_ready` is low.
- **Arbitration**: evaluated only in IDLE.
- **Widths**: nbytes ranges over 1..2047. The word index wraps at 512, which cannot occur for legal nbytes.

## Timing

- Reset (`rstn` low at a `clk` edge) takes effect at that edge and holds these values:
  - state = IDLE.
  - `m_valid`, `m_wstrb`, `m_addr`, `m_wdata` = 0.
  - All `*_dready`, `*_ack`, `*_err` = 0.
  - Round-robin pointer = "last granted B".
- Reset mid-frame abandons the frame with no ack; the core may hold a partially written buffer.
- Request high in IDLE at edge N: POLL `m_valid` is high from cycle N+1.
- Back-to-back DATA writes sustain one word per cycle when `dvalid` and `m_ready` are both high.
- Minimum frame latency with `m_ready` tied high and tx_ready = 1, from request to ack: 1 (IDLE) + 1 (POLL) + words + 3 (NBYTES, SEND1, SEND0) + 1 (DONE) cycles.
- `*_ack` and `*_err` are registered outputs.

## Configuration

- `IOB_ETH_TX_ARB_RR_EN` defined: round-robin arbitration. When both requests are high, the requester not granted last wins. After reset A wins first.
- Undefined: fixed priority; A always wins when both requests are high.

## Test plan

- **Single frame**: A requests 10 bytes, `m_ready` = 1, tx_ready = 1.
  - Expected bus sequence: 1 status read; 3 data writes at DATA_WR_ADDR+0..2; write 10 to NBYTES_ADDR; write 1 then 0 to SEND_ADDR.
  - `a_ack` high with `a_err` = 0 at cycle 9 after request.
- **Zero length**: B requests nbytes = 0 → `b_ack` and `b_err` = 1 two cycles later; no `m_valid` is asserted.
- **Poll timeout**: POLL_TIMEOUT = 4 and tx_ready held at 0 → exactly 4 status reads, then `a_ack` with `a_err` = 1; no data writes occur.
- **Simultaneous requests**: A and B both request continuously.
  - With `IOB_ETH_TX_ARB_RR_EN`: grant order A, B, A, B.
  - Without it: order A, A, A, and B never gets a turn.
- **Backpressure**: `m_ready` random at 50% and `dvalid` gaps on a 46-byte frame.
  - 12 data writes occur, with addresses and data held stable while stalled.
  - `dready` is high only on accepted cycles.
  - NBYTES is written with 46.
- **Reset mid-DATA**: drive `rstn` low for 1 cycle after word 2 → outputs return to their reset values at the next edge; a fresh A request completes normally.

Source files
------------

// File: rtl/iob_eth_tx_arb.sv
// Arbitrates two frame requesters onto the Ethernet core register port: poll tx_ready, fill TX buffer, set length, pulse SEND.
// Build option IOB_ETH_TX_ARB_RR_EN selects round-robin arbitration; otherwise requester A has fixed priority.
module iob_eth_tx_arb #(
  parameter int          ADDR_W       = 12,
  parameter [ADDR_W-1:0] STATUS_ADDR  = '0,
  parameter [ADDR_W-1:0] NBYTES_ADDR  = '0,
  parameter [ADDR_W-1:0] SEND_ADDR    = '0,
  parameter [ADDR_W-1:0] DATA_WR_ADDR = '0,
  parameter [15:0]       POLL_TIMEOUT = 16'd1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              a_req,
  input  logic [10:0]       a_nbytes,
  input  logic              a_dvalid,
  input  logic [31:0]       a_wdata,
  output logic              a_dready,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic [10:0]       b_nbytes,
  input  logic              b_dvalid,
  input  logic [31:0]       b_wdata,
  output logic              b_dready,
  output logic              b_ack,
  output logic              b_err,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);

  typedef enum logic [2:0] {IDLE, POLL, DATA, NBYTES, SEND1, SEND0, DONE} state_t;

  state_t            state_q;
  logic              grant_b_q;
  logic [10:0]       nbytes_q;
  logic [8:0]        idx_q;
  logic [8:0]        last_idx_q;
  logic [15:0]       poll_cnt_q;
  logic              frame_err_q;
  logic              m_valid_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [3:0]        m_wstrb_q;
  logic              a_ack_q, b_ack_q, a_err_q, b_err_q;

  logic              req_vld;
  logic              pick_b;
  logic [10:0]       sel_nbytes;
  logic [11:0]       words_d;
  logic [15:0]       poll_cnt_d;
  logic              in_data;
  logic              g_dvalid;
  logic [31:0]       g_wdata;
  logic              data_xfer;
  logic              rdata_unused;

  // The requester being acked still shows req high that cycle, so nobody is granted then.
  assign req_vld = (a_req || b_req) && !a_ack_q && !b_ack_q;

`ifdef IOB_ETH_TX_ARB_RR_EN
  logic last_b_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_b_q <= 1'b1;
    end else if (state_q == IDLE && req_vld) begin
      last_b_q <= pick_b;
    end
  end

  assign pick_b = b_req && (!a_req || !last_b_q);
`else
  assign pick_b = b_req && !a_req;
`endif

  assign sel_nbytes = pick_b ? b_nbytes : a_nbytes;
  assign words_d    = (12'(sel_nbytes) + 12'd3) >> 2;
  assign poll_cnt_d = poll_cnt_q + 16'd1;

  // Data words bypass the output registers so one word per cycle can stream through.
  assign in_data   = (state_q == DATA);
  assign g_dvalid  = grant_b_q ? b_dvalid : a_dvalid;
  assign g_wdata   = grant_b_q ? b_wdata : a_wdata;
  assign data_xfer = in_data && g_dvalid && m_ready;

  assign m_valid  = in_data ? g_dvalid : m_valid_q;
  assign m_addr   = in_data ? (DATA_WR_ADDR + ADDR_W'(idx_q)) : m_addr_q;
  assign m_wdata  = in_data ? g_wdata : m_wdata_q;
  assign m_wstrb  = in_data ? 4'hF : m_wstrb_q;
  assign a_dready = data_xfer && !grant_b_q;
  assign b_dready = data_xfer && grant_b_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;

  assign rdata_unused = ^m_rdata[31:1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_b_q   <= 1'b0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      poll_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_vld) begin
            grant_b_q  <= pick_b;
            nbytes_q   <= sel_nbytes;
            last_idx_q <= 9'(words_d - 12'd1);
            idx_q      <= '0;
            poll_cnt_q <= '0;
            if (sel_nbytes == 11'd0) begin
              frame_err_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              frame_err_q <= 1'b0;
              m_valid_q   <= 1'b1;
              m_addr_q    <= STATUS_ADDR;
              m_wdata_q   <= '0;
              m_wstrb_q   <= 4'h0;
              state_q     <= POLL;
            end
          end
        end
        POLL: begin
          if (m_ready) begin
            if (m_rdata[0]) begin
              m_valid_q <= 1'b0;
              state_q   <= DATA;
            end else if (poll_cnt_d == POLL_TIMEOUT) begin
              m_valid_q   <= 1'b0;
              frame_err_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              poll_cnt_q <= poll_cnt_d;
            end
          end
        end
        DATA: begin
          if (data_xfer) begin
            idx_q <= idx_q + 9'd1;
            if (idx_q == last_idx_q) begin
              m_valid_q <= 1'b1;
              m_addr_q  <= NBYTES_ADDR;
              m_wdata_q <= {21'b0, nbytes_q};
              m_wstrb_q <= 4'hF;
              state_q   <= NBYTES;
            end
          end
        end
        NBYTES: begin
          if (m_ready) begin
            m_addr_q  <= SEND_ADDR;
            m_wdata_q <= 32'd1;
            state_q   <= SEND1;
          end
        end
        SEND1: begin
          if (m_ready) begin
            m_wdata_q <= 32'd0;
            state_q   <= SEND0;
          end
        end
        SEND0: begin
          if (m_ready) begin
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wstrb_q   <= 4'h0;
            frame_err_q <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          a_ack_q <= !grant_b_q;
          b_ack_q <= grant_b_q;
          a_err_q <= !grant_b_q && frame_err_q;
          b_err_q <= grant_b_q && frame_err_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_tx_arb.sv
`timescale 1ns/1ps
module tb_iob_eth_tx_arb;
  localparam logic [11:0] ST_A = 12'h010;
  localparam logic [11:0] NB_A = 12'h014;
  localparam logic [11:0] SD_A = 12'h018;
  localparam logic [11:0] DW_A = 12'h400;
`ifdef IOB_ETH_TX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0;
  logic a_req = 1'b0, b_req = 1'b0;
  logic [10:0] a_nbytes = '0, b_nbytes = '0;
  logic a_dvalid = 1'b0, b_dvalid = 1'b0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic a_dready, b_dready, a_ack, b_ack, a_err, b_err;
  logic m_valid;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0] m_wstrb;
  logic [31:0] m_rdata = '0;
  logic m_ready = 1'b0;

  always #5 clk = ~clk;

  iob_eth_tx_arb #(
    .ADDR_W(12), .STATUS_ADDR(ST_A), .NBYTES_ADDR(NB_A), .SEND_ADDR(SD_A),
    .DATA_WR_ADDR(DW_A), .POLL_TIMEOUT(16'd4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_nbytes(a_nbytes), .a_dvalid(a_dvalid), .a_wdata(a_wdata),
    .a_dready(a_dready), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_nbytes(b_nbytes), .b_dvalid(b_dvalid), .b_wdata(b_wdata),
    .b_dready(b_dready), .b_ack(b_ack), .b_err(b_err),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  typedef struct {bit is_b; logic err; int cyc;} ack_t;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  logic tx_ready = 1'b1;
  bit rand_ready = 1'b0, gaps = 1'b0;
  bit a_cont = 1'b0, b_cont = 1'b0;
  int a_ptr = 0, b_ptr = 0, a_words = 0, b_words = 0;
  logic [31:0] a_mem [512];
  logic [31:0] b_mem [512];
  logic [47:0] bus_q[$];
  logic [47:0] exp_q[$];
  ack_t ack_q[$];
  int viol = 0, mvalid_seen = 0, first_mv = -1;
  bit stall_q = 1'b0;
  logic [11:0] stall_addr;
  logic [31:0] stall_data;
  bit a_acc, b_acc, a_seen_ack, b_seen_ack;

  // One clock: observe the bus at the negedge, then drive requesters and slave after the posedge.
  task automatic step();
    @(negedge clk);
    if (m_valid) mvalid_seen++;
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (stall_q && (!m_valid || m_addr !== stall_addr || m_wdata !== stall_data)) viol++;
    stall_q = m_valid && !m_ready;
    stall_addr = m_addr;
    stall_data = m_wdata;
    if (a_dready && !(m_valid && m_ready && a_dvalid)) viol++;
    if (b_dready && !(m_valid && m_ready && b_dvalid)) viol++;
    if (a_dready && b_dready) viol++;
    if (a_ack && b_ack) viol++;
    if (m_valid && m_ready)
      bus_q.push_back(m_wstrb == 4'h0 ? {m_addr, 4'h0, 32'h0} : {m_addr, m_wstrb, m_wdata});
    a_acc = a_dvalid && a_dready;
    b_acc = b_dvalid && b_dready;
    a_seen_ack = a_ack;
    b_seen_ack = b_ack;
    if (a_ack) ack_q.push_back('{1'b0, a_err, cyc});
    if (b_ack) ack_q.push_back('{1'b1, b_err, cyc});
    @(posedge clk);
    cyc++;
    #1;
    if (a_acc) a_ptr++;
    if (a_seen_ack) begin
      a_ptr = 0; a_dvalid = 1'b0;
      if (!a_cont) a_req = 1'b0;
    end else if (!(a_dvalid && !a_acc)) begin
      a_dvalid = a_req && (a_ptr < a_words) && (!gaps || $urandom_range(3) != 0);
    end
    a_wdata = a_mem[a_ptr % 512];
    if (b_acc) b_ptr++;
    if (b_seen_ack) begin
      b_ptr = 0; b_dvalid = 1'b0;
      if (!b_cont) b_req = 1'b0;
    end else if (!(b_dvalid && !b_acc)) begin
      b_dvalid = b_req && (b_ptr < b_words) && (!gaps || $urandom_range(3) != 0);
    end
    b_wdata = b_mem[b_ptr % 512];
    m_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
    m_rdata = ($urandom() & 32'hFFFF_FFFE) | {31'h0, tx_ready};
  endtask

  task automatic start_a(input int n);
    for (int i = 0; i < 512; i++) a_mem[i] = $urandom();
    a_nbytes = 11'(n); a_words = (n + 3) / 4; a_ptr = 0; a_req = 1'b1;
  endtask

  task automatic start_b(input int n);
    for (int i = 0; i < 512; i++) b_mem[i] = $urandom();
    b_nbytes = 11'(n); b_words = (n + 3) / 4; b_ptr = 0; b_req = 1'b1;
  endtask

  // Reference bus trace of one frame as seen by the core.
  task automatic expect_frame(input bit is_b, input int n, input int reads);
    for (int i = 0; i < reads; i++) exp_q.push_back({ST_A, 4'h0, 32'h0});
    for (int i = 0; i < (n + 3) / 4; i++)
      exp_q.push_back({12'(DW_A + i), 4'hF, (is_b ? b_mem[i] : a_mem[i])});
    exp_q.push_back({NB_A, 4'hF, 32'(n)});
    exp_q.push_back({SD_A, 4'hF, 32'd1});
    exp_q.push_back({SD_A, 4'hF, 32'd0});
  endtask

  task automatic wait_acks(input int k, input int budget, output bit ok);
    int t = 0;
    while (ack_q.size() < k && t < budget) begin step(); t++; end
    ok = (ack_q.size() >= k);
  endtask

  task automatic clear_logs();
    bus_q.delete(); exp_q.delete(); ack_q.delete();
    viol = 0; mvalid_seen = 0; first_mv = -1;
  endtask

  function automatic int first_diff();
    int n = (bus_q.size() < exp_q.size()) ? bus_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (bus_q[i] !== exp_q[i]) return i;
    if (bus_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [47:0] q_at(input logic [47:0] q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 48'hx;
  endfunction

  function automatic int count_data();
    int c = 0;
    foreach (bus_q[i]) if (bus_q[i][35:32] == 4'hF && bus_q[i][47:36] >= DW_A) c++;
    return c;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== 49'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h, want 0", {m_valid, m_addr, m_wdata, m_wstrb});
    end
    n_checks++;
    if ({a_dready, b_dready, a_ack, b_ack, a_err, b_err} !== 6'h0) begin
      n_fail++; $display("FAIL reset_hs: got %b, want 000000", {a_dready, b_dready, a_ack, b_ack, a_err, b_err});
    end
    @(posedge clk); cyc++; #1;
    rstn = 1'b1; m_ready = 1'b1; m_rdata = {31'h0, tx_ready};
  endtask

  task automatic test_single_frame();
    int c0, d; bit ok;
    clear_logs(); rand_ready = 1'b0; gaps = 1'b0; tx_ready = 1'b1;
    start_a(10); c0 = cyc; expect_frame(1'b0, 10, 1);
    wait_acks(1, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_ack: got 0 acks in 60 cycles, want 1"); end
    if (ok) begin
      n_checks++;
      if (ack_q[0].is_b !== 1'b0 || ack_q[0].err !== 1'b0) begin
        n_fail++; $display("FAIL single_who: got b=%0d err=%b, want b=0 err=0", ack_q[0].is_b, ack_q[0].err);
      end
      n_checks++;
      if (ack_q[0].cyc !== c0 + 9) begin
        n_fail++; $display("FAIL single_latency: ack at +%0d, want +9", ack_q[0].cyc - c0);
      end
    end
    n_checks++;
    if (first_mv !== c0 + 1) begin
      n_fail++; $display("FAIL single_poll_start: m_valid first at +%0d, want +1", first_mv - c0);
    end
    d = first_diff(); n_checks++;
    if (d !== -1) begin
      n_fail++; $display("FAIL single_bus: txn %0d got %h want %h (%0d txns, want %0d)",
                         d, q_at(bus_q, d), q_at(exp_q, d), bus_q.size(), exp_q.size());
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL single_proto: got %0d violations, want 0", viol); end
    step(); step();
  endtask

  task automatic test_zero_length();
    int c0; bit ok;
    clear_logs();
    start_b(0); c0 = cyc;
    wait_acks(1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL zero_ack: got 0 acks in 20 cycles, want 1"); end
    if (ok) begin
      n_checks++;
      if (ack_q[0].is_b !== 1'b1 || ack_q[0].err !== 1'b1) begin
        n_fail++; $display("FAIL zero_who: got b=%0d err=%b, want b=1 err=1", ack_q[0].is_b, ack_q[0].err);
      end
      n_checks++;
      if (ack_q[0].cyc !== c0 + 2) begin
        n_fail++; $display("FAIL zero_latency: ack at +%0d, want +2", ack_q[0].cyc - c0);
      end
    end
    n_checks++;
    if (mvalid_seen !== 0) begin n_fail++; $display("FAIL zero_bus: m_valid seen %0d cycles, want 0", mvalid_seen); end
    step();
  endtask

  task automatic test_poll_timeout();
    int d; bit ok;
    clear_logs(); tx_ready = 1'b0;
    start_a(8);
    for (int i = 0; i < 4; i++) exp_q.push_back({ST_A, 4'h0, 32'h0});
    wait_acks(1, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_ack: got 0 acks in 60 cycles, want 1"); end
    if (ok) begin
      n_checks++;
      if (ack_q[0].is_b !== 1'b0 || ack_q[0].err !== 1'b1) begin
        n_fail++; $display("FAIL timeout_who: got b=%0d err=%b, want b=0 err=1", ack_q[0].is_b, ack_q[0].err);
      end
    end
    d = first_diff(); n_checks++;
    if (d !== -1) begin
      n_fail++; $display("FAIL timeout_bus: txn %0d got %h want %h (%0d txns, want %0d)",
                         d, q_at(bus_q, d), q_at(exp_q, d), bus_q.size(), exp_q.size());
    end
    tx_ready = 1'b1;
    step();
  endtask

  task automatic test_simultaneous();
    bit ok, last_b, want_b;
    rstn = 1'b0; @(posedge clk); cyc++; #1; rstn = 1'b1; stall_q = 1'b0;
    clear_logs();
    a_cont = 1'b1; b_cont = 1'b1;
    start_a(4); start_b(8);
    wait_acks(4, 300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL simul_acks: got %0d acks, want 4", ack_q.size()); end
    last_b = 1'b1;
    if (ok) for (int i = 0; i < 4; i++) begin
      want_b = (RR && a_req && b_req) ? !last_b : 1'b0;
      last_b = want_b;
      n_checks++;
      if (ack_q[i].is_b !== want_b || ack_q[i].err !== 1'b0) begin
        n_fail++; $display("FAIL simul_order%0d: got b=%0d err=%b, want b=%0d err=0", i, ack_q[i].is_b, ack_q[i].err, want_b);
      end
    end
    a_cont = 1'b0; b_cont = 1'b0;
    for (int t = 0; t < 400 && (a_req || b_req); t++) step();
    n_checks++;
    if (a_req || b_req) begin n_fail++; $display("FAIL simul_drain: req a=%b b=%b still pending, want both served", a_req, b_req); end
    step();
  endtask

  task automatic test_backpressure();
    int d; bit ok;
    clear_logs(); rand_ready = 1'b1; gaps = 1'b1;
    start_b(46); expect_frame(1'b1, 46, 1);
    wait_acks(1, 2000, ok);
    n_checks++;
    if (!ok || ack_q[0].is_b !== 1'b1 || ack_q[0].err !== 1'b0) begin
      n_fail++; $display("FAIL bp_ack: got %0d acks, want one B ack with err=0", ack_q.size());
    end
    n_checks++;
    if (count_data() !== 12) begin n_fail++; $display("FAIL bp_words: got %0d data writes, want 12", count_data()); end
    d = first_diff(); n_checks++;
    if (d !== -1) begin
      n_fail++; $display("FAIL bp_bus: txn %0d got %h want %h (%0d txns, want %0d)",
                         d, q_at(bus_q, d), q_at(exp_q, d), bus_q.size(), exp_q.size());
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL bp_proto: got %0d violations, want 0", viol); end
    rand_ready = 1'b0; gaps = 1'b0;
    step();
  endtask

  task automatic test_random_frames();
    int d, n; bit ok, is_b;
    rand_ready = 1'b1; gaps = 1'b1;
    for (int f = 0; f < 6; f++) begin
      clear_logs();
      is_b = ($urandom_range(1) == 1);
      n = $urandom_range(80, 1);
      if (is_b) start_b(n); else start_a(n);
      expect_frame(is_b, n, 1);
      wait_acks(1, 2000, ok);
      n_checks++;
      if (!ok || ack_q[0].is_b !== is_b || ack_q[0].err !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_ack: got %0d acks, want one ack b=%0d err=0 (n=%0d)", f, ack_q.size(), is_b, n);
      end
      d = first_diff(); n_checks++;
      if (d !== -1 || viol !== 0) begin
        n_fail++; $display("FAIL rand%0d_bus: txn %0d got %h want %h, %0d violations (n=%0d)",
                           f, d, q_at(bus_q, d), q_at(exp_q, d), viol, n);
      end
    end
    rand_ready = 1'b0; gaps = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_data();
    int c0, d, t; bit ok;
    clear_logs();
    start_a(40);
    t = 0;
    while (count_data() < 3 && t < 50) begin step(); t++; end
    n_checks++;
    if (count_data() < 3) begin n_fail++; $display("FAIL rst_mid_reach: got %0d data writes, want 3", count_data()); end
    rstn = 1'b0; a_req = 1'b0; a_dvalid = 1'b0;
    @(posedge clk); cyc++; #1;
    rstn = 1'b1; stall_q = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== 49'h0) begin
      n_fail++; $display("FAIL rst_mid_bus: got %h, want 0", {m_valid, m_addr, m_wdata, m_wstrb});
    end
    n_checks++;
    if ({a_dready, b_dready, a_ack, b_ack, a_err, b_err} !== 6'h0) begin
      n_fail++; $display("FAIL rst_mid_hs: got %b, want 000000", {a_dready, b_dready, a_ack, b_ack, a_err, b_err});
    end
    @(posedge clk); cyc++; #1;
    clear_logs();
    repeat (3) step();
    n_checks++;
    if (ack_q.size() !== 0 || mvalid_seen !== 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got %0d acks %0d valid cycles, want 0 and 0", ack_q.size(), mvalid_seen);
    end
    clear_logs();
    start_a(10); c0 = cyc; expect_frame(1'b0, 10, 1);
    wait_acks(1, 60, ok);
    n_checks++;
    if (!ok || ack_q[0].err !== 1'b0 || ack_q[0].cyc !== c0 + 9) begin
      n_fail++; $display("FAIL rst_mid_fresh: got %0d acks (at +%0d), want one ack at +9 err=0",
                         ack_q.size(), ok ? ack_q[0].cyc - c0 : -1);
    end
    d = first_diff(); n_checks++;
    if (d !== -1) begin
      n_fail++; $display("FAIL rst_mid_bus2: txn %0d got %h want %h (%0d txns, want %0d)",
                         d, q_at(bus_q, d), q_at(exp_q, d), bus_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_zero_length();
    test_poll_timeout();
    test_simultaneous();
    test_backpressure();
    test_random_frames();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2ms, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
